mlsu_seq_info_buf: RTL
======================

# mlsu_seq_info_buf

Sequential-side meta-info buffer of the matrix load/store unit, directly downstream of the meta-info broadcast stage's sequential output. It queues up to `Depth` matrix meta-info entries and expands the head entry into one row request per matrix row, with a stride-accumulated address, for the sequential address/beat generator. It retires each entry after its last row is accepted.

## Interface
- `Depth`, 4: meta-info FIFO entries; power of two, ≥2.
- `AddrWidth`, 64: byte-address width.
- `RowWidth`, 16: row-count width.
- `LenWidth`, 16: row byte-length width.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `meta_valid_i` in 1: meta-info entry valid, from the broadcast stage's sequential output.
- `meta_ready_o` out 1: buffer can accept an entry.
- `meta_base_i` in AddrWidth: matrix base byte address.
- `meta_stride_i` in AddrWidth: row stride in bytes, two's complement.
- `meta_rows_i` in RowWidth: number of rows; 0 is legal.
- `meta_row_bytes_i` in LenWidth: bytes per row.
- `meta_store_i` in 1: 1 = store, 0 = load.
- `req_valid_o` out 1: row request valid.
- `req_ready_i` in 1: downstream accepts the row request.
- `req_addr_o` out AddrWidth: row start address.
- `req_bytes_o` out LenWidth: row length; equals the head entry's `meta_row_bytes_i`.
- `req_store_o` out 1: head entry's store flag.
- `req_last_o` out 1: this is the final row of the head entry.
- `busy_o` out 1: FIFO is non-empty.
- `count_o` out $clog2(Depth)+1: number of occupied entries.

## Operation
- Push: when `meta_valid_i && meta_ready_o`, write the entry at the write pointer.
- `meta_ready_o = (count < Depth)`. It is a function of registered count only. There is no same-cycle pop credit: when full, ready stays 0 even if a pop occurs in that cycle.
- Head expansion uses registers `row_q` (RowWidth) and `addr_q` (AddrWidth).
- Row 0 address: `req_addr_o = head.base` when `row_q == 0`; otherwise `req_addr_o = addr_q`.
- On each row handshake (`req_valid_o && req_ready_i`):
  - if not last: `row_q <= row_q + 1` and `addr_q <= req_addr_o + head.stride`.
  - if last: pop the head, `row_q <= 0`, `addr_q` is don't-care.
- Address arithmetic is modulo 2^AddrWidth. Overflow and underflow wrap silently.
- `req_last_o = (row_q == head.rows - 1)`.
- `req_valid_o = busy && head.rows != 0`.
- Zero-row head: pop it in the cycle it is at the head, with `req_valid_o` held at 0. This costs 1 cycle per zero-row entry.
- FSM, two states:
  - EMPTY: `count == 0`. Move to ACTIVE on push.
  - ACTIVE: `count > 0`. Return to EMPTY when a pop with no push leaves `count == 0`.
  - `busy_o = (state == ACTIVE)`.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers are `$clog2(Depth)` bits and wrap naturally.
- Entry fields and `row_q`/`addr_q` are registers. The outputs decode combinationally from the head entry and these registers.

## Timing
- Reset values: `meta_ready_o = 1`, `req_valid_o = 0`, `req_last_o = 0`, `busy_o = 0`, `count_o = 0`. `req_addr_o`, `req_bytes_o` and `req_store_o` reset to 0.
- Reset clears pointers, count, `row_q` and FSM state. Reset mid-operation discards all queued entries and partially issued rows. No request is replayed.
- Latency: an entry pushed at edge N gives `req_valid_o = 1` in cycle N+1 if the FIFO was empty. There is no flow-through from `meta_*` to `req_*`.
- Throughput: one row per cycle while `req_ready_i = 1`. Consecutive entries issue back-to-back, with no bubble between the last row of one entry and row 0 of the next.
- AXI-style hold rule: once `req_valid_o` is asserted, `req_valid_o` and all `req_*` outputs stay stable until the handshake.
- The upstream side must obey the same rule. The bench flags a retracted `meta_valid_i`; the RTL does not check it.

## Test plan
- Single entry: base 0x1000, stride 0x100, rows 3, bytes 64, store 0, `req_ready_i = 1`.
  - Addresses 0x1000, 0x1100, 0x1200 in three consecutive cycles starting 1 cycle after the push.
  - `req_last_o` is high only on 0x1200. `busy_o` drops the next cycle.
- Zero-row drop: push rows 0, then rows 1 with base 0x40.
  - No request for the first entry. A single request at 0x40 with `req_last_o = 1`.
- Full and backpressure: `req_ready_i = 0`, push 5 entries back-to-back.
  - 4 accepted, `count_o = 4`, `meta_ready_o = 0` on the fifth.
  - `req_*` stays stable through 10 stall cycles.
  - Release: 1 pop cycle later `meta_ready_o = 1`, and rows drain in FIFO order.
- Simultaneous push and pop: count at 2, push during a last-row handshake → `count_o` remains 2.
- Negative stride wrap: base 0x10, stride 0xFFFF_FFFF_FFFF_FFF0 (−16), rows 3 → addresses 0x10, 0x0, 0xFFFF_FFFF_FFFF_FFF0.
- Reset mid-entry: assert `rst_ni = 0` after row 1 of a 4-row entry.
  - All outputs take their reset values asynchronously.
  - After release, a fresh entry starts at its row 0.

Source files
------------

// File: rtl/mlsu_seq_info_buf.sv
// Sequential-side meta-info buffer for the matrix load/store unit.
// Queues matrix meta-info entries and expands the head entry into one
// row request per row, with a stride-accumulated start address.
module mlsu_seq_info_buf #(
  parameter int Depth     = 4,
  parameter int AddrWidth = 64,
  parameter int RowWidth  = 16,
  parameter int LenWidth  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       meta_valid_i,
  output logic                       meta_ready_o,
  input  logic [AddrWidth-1:0]       meta_base_i,
  input  logic [AddrWidth-1:0]       meta_stride_i,
  input  logic [RowWidth-1:0]        meta_rows_i,
  input  logic [LenWidth-1:0]        meta_row_bytes_i,
  input  logic                       meta_store_i,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  output logic [AddrWidth-1:0]       req_addr_o,
  output logic [LenWidth-1:0]        req_bytes_o,
  output logic                       req_store_o,
  output logic                       req_last_o,
  output logic                       busy_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  typedef struct packed {
    logic [AddrWidth-1:0] base;
    logic [AddrWidth-1:0] stride;
    logic [RowWidth-1:0]  rows;
    logic [LenWidth-1:0]  bytes;
    logic                 store;
  } entry_t;

  typedef enum logic {EMPTY, ACTIVE} state_e;

  entry_t               mem_q [Depth];
  entry_t               head;
  state_e               state_q;
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CntW-1:0]      count_q;
  logic [RowWidth-1:0]  row_q;
  logic [AddrWidth-1:0] addr_q;
  logic                 push, pop, fire;

  // Head decode: outputs come only from registered state, never from meta_*.
  assign head         = mem_q[rptr_q];
  assign busy_o       = (state_q == ACTIVE);
  assign count_o      = count_q;
  assign meta_ready_o = (count_q < CntW'(Depth));
  assign push         = meta_valid_i && meta_ready_o;
  assign req_valid_o  = busy_o && (head.rows != '0);
  assign req_addr_o   = (row_q == '0) ? head.base : addr_q;
  assign req_bytes_o  = head.bytes;
  assign req_store_o  = head.store;
  // With rows==0 the subtraction wraps to all-ones, so last never fires.
  assign req_last_o   = (row_q == head.rows - RowWidth'(1));
  assign fire         = req_valid_o && req_ready_i;
  // Zero-row heads retire silently in the cycle they reach the head.
  assign pop          = busy_o && ((head.rows == '0) || (fire && req_last_o));

  // Entry storage; cleared on reset so idle outputs read as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= '{base:   meta_base_i,   stride: meta_stride_i,
                         rows:   meta_rows_i,   bytes:  meta_row_bytes_i,
                         store:  meta_store_i};
    end
  end

  // Occupancy FSM with pointers and count; pointers wrap at Depth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      case (state_q)
        EMPTY:   if (push) state_q <= ACTIVE;
        ACTIVE:  if (pop && !push && count_q == CntW'(1)) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Row walker: advance row index and accumulate stride on each accepted row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q  <= '0;
      addr_q <= '0;
    end else if (fire) begin
      if (req_last_o) begin
        row_q <= '0;
      end else begin
        row_q  <= row_q + RowWidth'(1);
        addr_q <= req_addr_o + head.stride;
      end
    end
  end

endmodule
